// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU op codes driven on E_MDUOp
//   - default busy latencies for multiply and divide
//   - sequencer state encoding
//   - helper that classifies the ops needing the long-latency sequencer
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the sequencer for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath for the MDU.
//   i_op       : MDU op code (selects signed/unsigned multiply or divide)
//   i_a, i_b   : operands (rs, rt)
//   o_hi, o_lo : result halves ({HI,LO} = product, or HI = remainder, LO = quotient)
//   o_div_zero : divisor is zero (result halves are then meaningless)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'h0000_0000, i_a} * {32'h0000_0000, i_b};

  // Signed divide is done on magnitudes so the most-negative / -1 case never
  // overflows; 0x80000000 as an unsigned magnitude is exactly 2^31.
  assign w_signed_div = (i_op == OP_DIV);
  assign w_abs_a      = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_abs_b      = i_b[31] ? (32'd0 - i_b) : i_b;
  assign o_div_zero   = (i_b == 32'd0);
  assign w_dvd        = w_signed_div ? w_abs_a : i_a;
  // A dummy divisor of 1 keeps the divider well defined; the caller discards it.
  assign w_dvs        = o_div_zero ? 32'd1 : (w_signed_div ? w_abs_b : i_b);
  assign w_quo        = w_dvd / w_dvs;
  assign w_rem        = w_dvd % w_dvs;

  // Result selection; quotient sign is sign(a)^sign(b), remainder follows a.
  always_comb begin
    o_hi = 32'h0000_0000;
    o_lo = 32'h0000_0000;
    case (i_op)
      OP_MULT: begin
        o_hi = w_prod_s[63:32];
        o_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        o_hi = w_prod_u[63:32];
        o_lo = w_prod_u[31:0];
      end
      OP_DIV: begin
        o_lo = (i_a[31] ^ i_b[31]) ? (32'd0 - w_quo) : w_quo;
        o_hi = i_a[31] ? (32'd0 - w_rem) : w_rem;
      end
      OP_DIVU: begin
        o_lo = w_quo;
        o_hi = w_rem;
      end
      default: begin
        o_hi = 32'h0000_0000;
        o_lo = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer and HI/LO owner.
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   E_start      : E-stage MDU instruction valid this cycle
//   E_MDUOp      : op code (mdu_pkg OP_*)
//   E_RS, E_RT   : operands
//   D_MDUInstr   : D-stage instruction is MDU-class
//   busy         : long op in progress
//   stall_req    : stall D / freeze F/D (combinational)
//   done         : one-cycle pulse in the first cycle the new HI/LO are visible
//   HI, LO       : architectural HI/LO registers
// The result is computed at the start edge and parked in pending registers;
// the counter only models latency and commits the parked value on expiry.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_MDUInstr,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] w_pend_hi_nxt;
  logic [31:0] w_pend_lo_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        r_busy;
  logic        r_done;
  logic        w_done_nxt;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div_zero;

  mdu_arith u_arith (
    .i_op       (E_MDUOp),
    .i_a        (E_RS),
    .i_b        (E_RT),
    .o_hi       (w_res_hi),
    .o_lo       (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  // Next-state, counter, pending and HI/LO update logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (E_start) begin
          case (E_MDUOp)
            OP_MULT, OP_MULTU: begin
              w_pend_hi_nxt = w_res_hi;
              w_pend_lo_nxt = w_res_lo;
              w_cnt_nxt     = CW'(MULT_CYCLES);
              w_state_nxt   = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero re-commits the current HI/LO after the full latency.
              if (w_div_zero) begin
                w_pend_hi_nxt = r_hi;
                w_pend_lo_nxt = r_lo;
              end else begin
                w_pend_hi_nxt = w_res_hi;
                w_pend_lo_nxt = w_res_lo;
              end
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            OP_MTHI: w_hi_nxt = E_RS;
            OP_MTLO: w_lo_nxt = E_RS;
            default: w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Starts arriving here are illegal and deliberately ignored.
        if (r_cnt == CW'(1)) begin
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
          w_cnt_nxt   = CW'(0);
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CW'(0);
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CW'(0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_hi <= 32'h0000_0000;
      r_pend_lo <= 32'h0000_0000;
      r_hi      <= 32'h0000_0000;
      r_lo      <= 32'h0000_0000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_busy    <= (w_state_nxt == ST_BUSY);
      r_done    <= w_done_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign HI        = r_hi;
  assign LO        = r_lo;
  // Covers the start cycle too, before busy has risen.
  assign stall_req = D_MDUInstr & (r_busy | (E_start & is_long_op(E_MDUOp)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 time unit after an input change for the combinational stall_req.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        E_start = 1'b0;
  logic [3:0]  E_MDUOp = 4'd0;
  logic [31:0] E_RS = 32'd0;
  logic [31:0] E_RT = 32'd0;
  logic        D_MDUInstr = 1'b0;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;
  int n_illegal = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_start    (E_start),
    .E_MDUOp    (E_MDUOp),
    .E_RS       (E_RS),
    .E_RT       (E_RT),
    .D_MDUInstr (D_MDUInstr),
    .busy       (busy),
    .stall_req  (stall_req),
    .done       (done),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  // Records any start presented while the sequencer is busy.
  always @(posedge clk) begin
    if (E_start && busy) n_illegal++;
  end

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, stall_req} !== 3'b000 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold: busy/done/stall=%b%b%b HI=%h LO=%h, want 000 0 0", busy, done, stall_req, HI, LO);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, stall_req} !== 3'b000 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy/done/stall=%b%b%b HI=%h LO=%h, want 000 0 0", busy, done, stall_req, HI, LO);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  // Runs one long op with d as the D-stage MDU flag and checks the full timeline.
  task automatic run_long(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic d, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    E_MDUOp = op; E_RS = a; E_RT = b; D_MDUInstr = d; E_start = 1'b1;
    #1;
    n_checks++;
    if (stall_req !== d || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: stall=%b busy=%b, want stall=%b busy=0", name, stall_req, busy, d);
    end
    @(posedge clk);
    #1 E_start = 1'b0; E_MDUOp = OP_NONE;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || stall_req !== d || HI !== m_hi || LO !== m_lo) begin
        n_fail++;
        $display("FAIL %s_busy%0d: busy=%b done=%b stall=%b HI=%h LO=%h, want 1 0 %b %h %h",
                 name, i, busy, done, stall_req, HI, LO, d, m_hi, m_lo);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || stall_req !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      n_fail++;
      $display("FAIL %s_commit: busy=%b done=%b stall=%b HI=%h LO=%h, want 0 1 0 %h %h",
               name, busy, done, stall_req, HI, LO, exp_hi, exp_lo);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      n_fail++;
      $display("FAIL %s_after: done=%b busy=%b HI=%h LO=%h, want 0 0 %h %h", name, done, busy, HI, LO, m_hi, m_lo);
    end
    D_MDUInstr = 1'b0;
  endtask

  // Single-cycle op (MTHI/MTLO/MFHI/MFLO) with D-stage MDU flag raised.
  task automatic run_short(input string name, input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    E_MDUOp = op; E_RS = a; E_RT = 32'd0; D_MDUInstr = 1'b1; E_start = 1'b1;
    #1;
    n_checks++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_stall: stall=%b, want 0", name, stall_req);
    end
    @(posedge clk);
    #1 E_start = 1'b0; E_MDUOp = OP_NONE; D_MDUInstr = 1'b0;
    if (op == OP_MTHI) m_hi = a;
    else if (op == OP_MTLO) m_lo = a;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      n_fail++;
      $display("FAIL %s_result: busy=%b done=%b HI=%h LO=%h, want 0 0 %h %h", name, busy, done, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_mult();
    run_long("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_long("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_div();
    run_long("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_long("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    run_short("mthi", OP_MTHI, 32'h0000_1234);
    run_short("mtlo", OP_MTLO, 32'h0000_5678);
    run_short("mfhi", OP_MFHI, 32'hDEAD_BEEF);
    run_long("div_zero", OP_DIV, 32'h0000_0077, 32'd0, 1'b1, 10, 32'h0000_1234, 32'h0000_5678);
  endtask

  task automatic test_back_to_back();
    run_long("b2b_mult", OP_MULT, 32'd7, 32'hFFFF_FFFF, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_long("b2b_divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 10, 32'h0000_0002, 32'h0000_000E);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge clk);
    E_MDUOp = OP_DIVU; E_RS = 32'd100; E_RT = 32'd7; D_MDUInstr = 1'b0; E_start = 1'b1;
    @(posedge clk);
    #1 E_start = 1'b0; E_MDUOp = OP_NONE;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_busy4: busy=%b, want 1", busy);
    end
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_async: busy=%b done=%b HI=%h LO=%h, want 0 0 0 0", busy, done, HI, LO);
    end
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_after: done/busy cycles=%0d HI=%h LO=%h, want 0 0 0", done_seen, HI, LO);
    end
  endtask

  task automatic test_no_illegal_start();
    n_checks++;
    if (n_illegal != 0) begin
      n_fail++;
      $display("FAIL illegal_start: starts while busy=%0d, want 0", n_illegal);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_no_illegal_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
